// File: rtl/mips_mc_control_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package mips_mc_control_pkg;

  // State codes are visible on state_o for debug.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_ctl_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // Per-state datapath controls; mem_wait marks states whose write
  // enables only fire on the cycle the memory reports ready.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       mem_wait;
    alu_op_t    aluop;
  } ctrl_t;

  function automatic logic op_supported(logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

  // Moore decode of the control word for a given state.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusrcb  = 2'b01;
        c.irwrite  = 1'b1;
        c.pcwrite  = 1'b1;
        c.mem_wait = 1'b1;
      end
      S_DECODE: c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMREAD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
        c.mem_wait = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDIWB: c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control/datapath bundle; the control unit is the master side.
interface mips_mc_control_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_rdy;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       PCEn;
  logic [2:0] ALUCtl;
  logic       illegal_op;
  logic [3:0] state_o;

  modport master (
    input  Op, Funct, Zero, mem_rdy,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, ALUCtl, illegal_op, state_o
  );

  modport slave (
    output Op, Funct, Zero, mem_rdy,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, PCEn, ALUCtl, illegal_op, state_o
  );
endinterface

// File: rtl/mips_mc_control_alu_decoder.sv
// ALUOp + Funct -> ALU operation select, with an unsupported-funct flag.
module alu_decoder
  import mips_mc_control_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output alu_ctl_t   alu_ctl,
  output logic       bad_funct
);

  // Funct is only consulted for R-type execution; unknown functs fall back to add.
  always_comb begin
    alu_ctl   = ALU_ADD;
    bad_funct = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: bad_funct = 1'b1;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared datapath.
module mips_mc_control
  import mips_mc_control_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  mips_mc_control_if.master bus
);

  state_t   state;
  state_t   nxt;
  ctrl_t    ctrl_q;
  alu_op_t  alu_op;
  alu_ctl_t alu_ctl;
  logic     bad_funct;
  logic     rdy_ok;
  logic     en_ok;

  assign rdy_ok = bus.mem_rdy | ~MEM_WAIT_EN;

  // Next-state selection; Op is taken from the held IR, memory states wait on ready.
  always_comb begin
    nxt = state;
    case (state)
      S_FETCH: if (rdy_ok) nxt = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXECUTE;
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_ADDIEXEC;
          OP_J:         nxt = S_JUMP;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.Op == OP_LW)      nxt = S_MEMREAD;
        else if (bus.Op == OP_SW) nxt = S_MEMWRITE;
        else                      nxt = S_FETCH;
      end
      S_MEMREAD:  if (rdy_ok) nxt = S_MEMWB;
      S_MEMWRITE: if (rdy_ok) nxt = S_FETCH;
      S_EXECUTE:  nxt = S_ALUWB;
      S_ADDIEXEC: nxt = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: nxt = S_FETCH;
      default:    nxt = S_FETCH;
    endcase
  end

  // State register with the control word registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FETCH;
      ctrl_q <= state_ctrl(S_FETCH);
    end else begin
      state  <= nxt;
      ctrl_q <= state_ctrl(nxt);
    end
  end

  assign alu_op = rst_n ? ctrl_q.aluop : ALUOP_ADD;

  alu_decoder u_alu_decoder (
    .alu_op    (alu_op),
    .funct     (bus.Funct),
    .alu_ctl   (alu_ctl),
    .bad_funct (bad_funct)
  );

  // Enables of memory-waiting states fire only on the ready cycle; everything is dead in reset.
  assign en_ok = rst_n & (rdy_ok | ~ctrl_q.mem_wait);

  assign bus.IorD       = rst_n & ctrl_q.iord;
  assign bus.MemWrite   = en_ok & ctrl_q.memwrite;
  assign bus.IRWrite    = en_ok & ctrl_q.irwrite;
  assign bus.RegDst     = rst_n & ctrl_q.regdst;
  assign bus.MemtoReg   = rst_n & ctrl_q.memtoreg;
  assign bus.RegWrite   = rst_n & ctrl_q.regwrite;
  assign bus.ALUSrcA    = rst_n & ctrl_q.alusrca;
  assign bus.ALUSrcB    = rst_n ? ctrl_q.alusrcb : 2'b00;
  assign bus.PCSrc      = rst_n ? ctrl_q.pcsrc : 2'b00;
  assign bus.PCEn       = (en_ok & ctrl_q.pcwrite) | (rst_n & ctrl_q.branch & bus.Zero);
  assign bus.ALUCtl     = alu_ctl;
  assign bus.illegal_op = rst_n & (((state == S_DECODE) & ~op_supported(bus.Op)) |
                                   ((state == S_EXECUTE) & bad_funct));
  assign bus.state_o    = state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench: instruction-level reference model driving directed and random programs.
module tb_mips_mc_control;
  import mips_mc_control_pkg::*;

  localparam logic [5:0] TB_OP_R    = 6'b000000;
  localparam logic [5:0] TB_OP_LW   = 6'b100011;
  localparam logic [5:0] TB_OP_SW   = 6'b101011;
  localparam logic [5:0] TB_OP_BEQ  = 6'b000100;
  localparam logic [5:0] TB_OP_ADDI = 6'b001000;
  localparam logic [5:0] TB_OP_J    = 6'b000010;

  typedef enum int {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECUTE, T_ALUWB, T_BRANCH, T_ADDIEXEC, T_ADDIWB, T_JUMP
  } tb_step_e;

  // -1 in any field means the value is not defined for that step.
  typedef struct {
    int st, iord, memwrite, irwrite, regdst, memtoreg, regwrite;
    int alusrca, alusrcb, pcsrc, pcen, aluctl, illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [5:0] legalOps [6] = '{TB_OP_R, TB_OP_LW, TB_OP_SW, TB_OP_BEQ, TB_OP_ADDI, TB_OP_J};
  logic [5:0] legalFns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  mips_mc_control_if bus ();

  mips_mc_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int functCode(logic [5:0] fn);
    case (fn)
      6'b100000: return 0;
      6'b100010: return 1;
      6'b100100: return 2;
      6'b100101: return 3;
      6'b101010: return 4;
      default:   return -1;
    endcase
  endfunction

  function automatic bit opLegal(logic [5:0] op);
    foreach (legalOps[i]) if (legalOps[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Expected outputs for one cycle of an instruction step, from the per-step control rules.
  function automatic exp_t expectFor(tb_step_e s, logic [5:0] op, logic [5:0] fn, logic rdy, logic zero);
    exp_t e;
    e = '{default: -1};
    e.memwrite = 0; e.irwrite = 0; e.regwrite = 0; e.pcen = 0; e.illegal = 0;
    case (s)
      T_FETCH: begin
        e.st = 0; e.iord = 0; e.alusrca = 0; e.alusrcb = 1; e.aluctl = 0; e.pcsrc = 0;
        e.irwrite = int'(rdy); e.pcen = int'(rdy);
      end
      T_DECODE: begin
        e.st = 1; e.alusrca = 0; e.alusrcb = 3; e.aluctl = 0;
        e.illegal = opLegal(op) ? 0 : 1;
      end
      T_MEMADR:   begin e.st = 2; e.alusrca = 1; e.alusrcb = 2; e.aluctl = 0; end
      T_MEMREAD:  begin e.st = 3; e.iord = 1; end
      T_MEMWB:    begin e.st = 4; e.regdst = 0; e.memtoreg = 1; e.regwrite = 1; end
      T_MEMWRITE: begin e.st = 5; e.iord = 1; e.memwrite = int'(rdy); end
      T_EXECUTE: begin
        e.st = 6; e.alusrca = 1; e.alusrcb = 0;
        e.aluctl  = (functCode(fn) < 0) ? 0 : functCode(fn);
        e.illegal = (functCode(fn) < 0) ? 1 : 0;
      end
      T_ALUWB:    begin e.st = 7; e.regdst = 1; e.memtoreg = 0; e.regwrite = 1; end
      T_BRANCH: begin
        e.st = 8; e.alusrca = 1; e.alusrcb = 0; e.aluctl = 1; e.pcsrc = 1; e.pcen = int'(zero);
      end
      T_ADDIEXEC: begin e.st = 9; e.alusrca = 1; e.alusrcb = 2; e.aluctl = 0; end
      T_ADDIWB:   begin e.st = 10; e.regdst = 0; e.regwrite = 1; end
      T_JUMP:     begin e.st = 11; e.pcsrc = 2; e.pcen = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t resetExpect();
    exp_t e;
    e = '{default: 0};
    return e;
  endfunction

  task automatic compareField(input string tag, input logic [3:0] obs, input int exp);
    if (exp >= 0) begin
      checks++;
      assert (obs === 4'(exp)) else begin
        failures++;
        $error("[TB] FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("state_o",    bus.state_o,            e.st);
    compareField("IorD",       {3'b0, bus.IorD},       e.iord);
    compareField("MemWrite",   {3'b0, bus.MemWrite},   e.memwrite);
    compareField("IRWrite",    {3'b0, bus.IRWrite},    e.irwrite);
    compareField("RegDst",     {3'b0, bus.RegDst},     e.regdst);
    compareField("MemtoReg",   {3'b0, bus.MemtoReg},   e.memtoreg);
    compareField("RegWrite",   {3'b0, bus.RegWrite},   e.regwrite);
    compareField("ALUSrcA",    {3'b0, bus.ALUSrcA},    e.alusrca);
    compareField("ALUSrcB",    {2'b0, bus.ALUSrcB},    e.alusrcb);
    compareField("PCSrc",      {2'b0, bus.PCSrc},      e.pcsrc);
    compareField("PCEn",       {3'b0, bus.PCEn},       e.pcen);
    compareField("ALUCtl",     {1'b0, bus.ALUCtl},     e.aluctl);
    compareField("illegal_op", {3'b0, bus.illegal_op}, e.illegal);
  endtask

  // One clock cycle of a step: drive inputs after the edge, check mid-cycle, advance.
  task automatic applyStimulus(input tb_step_e s, input logic [5:0] op, input logic [5:0] fn,
                               input logic rdy, input logic zero);
    if (s == T_FETCH) begin
      bus.Op    = 6'($urandom);
      bus.Funct = 6'($urandom);
    end else begin
      bus.Op    = op;
      bus.Funct = fn;
    end
    bus.mem_rdy = rdy;
    bus.Zero    = zero;
    @(negedge clk);
    checkOutput(expectFor(s, op, fn, rdy, zero));
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction; negative wait/zero arguments mean randomize.
  task automatic runInstruction(input logic [5:0] op, input logic [5:0] fn,
                                input int fetchWaits, input int memWaits, input int zeroSel);
    tb_step_e plan[$];
    plan.push_back(T_FETCH);
    plan.push_back(T_DECODE);
    case (op)
      TB_OP_R:    begin plan.push_back(T_EXECUTE); plan.push_back(T_ALUWB); end
      TB_OP_LW:   begin plan.push_back(T_MEMADR); plan.push_back(T_MEMREAD); plan.push_back(T_MEMWB); end
      TB_OP_SW:   begin plan.push_back(T_MEMADR); plan.push_back(T_MEMWRITE); end
      TB_OP_BEQ:  plan.push_back(T_BRANCH);
      TB_OP_ADDI: begin plan.push_back(T_ADDIEXEC); plan.push_back(T_ADDIWB); end
      TB_OP_J:    plan.push_back(T_JUMP);
      default: ;
    endcase
    foreach (plan[i]) begin
      int   waits;
      logic z;
      waits = 0;
      z = (zeroSel < 0) ? 1'($urandom_range(0, 1)) : 1'(zeroSel);
      if (plan[i] == T_FETCH)
        waits = (fetchWaits < 0) ? int'($urandom_range(0, 2)) : fetchWaits;
      else if (plan[i] == T_MEMREAD || plan[i] == T_MEMWRITE)
        waits = (memWaits < 0) ? int'($urandom_range(0, 2)) : memWaits;
      if (plan[i] == T_FETCH || plan[i] == T_MEMREAD || plan[i] == T_MEMWRITE) begin
        repeat (waits) applyStimulus(plan[i], op, fn, 1'b0, z);
        applyStimulus(plan[i], op, fn, 1'b1, z);
      end else begin
        applyStimulus(plan[i], op, fn, 1'($urandom_range(0, 1)), z);
      end
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;

    rst_n       = 1'b0;
    bus.Op      = '0;
    bus.Funct   = '0;
    bus.Zero    = 1'b0;
    bus.mem_rdy = 1'b0;
    #1;
    checkOutput(resetExpect());
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    runInstruction(TB_OP_R, 6'b100000, 0, 0, -1);
    runInstruction(TB_OP_LW, 6'b000000, 0, 2, -1);
    runInstruction(TB_OP_BEQ, 6'b000000, 0, 0, 1);
    runInstruction(TB_OP_BEQ, 6'b000000, 0, 0, 0);
    runInstruction(TB_OP_R, 6'b101010, 0, 0, -1);
    runInstruction(TB_OP_R, 6'b100101, 0, 0, -1);
    runInstruction(TB_OP_R, 6'b111111, 0, 0, -1);
    runInstruction(6'b111111, 6'b000000, 0, 0, -1);
    runInstruction(TB_OP_SW, 6'b000000, 1, 1, -1);
    runInstruction(TB_OP_ADDI, 6'b000000, 0, 0, -1);
    runInstruction(TB_OP_J, 6'b000000, 0, 0, -1);

    applyStimulus(T_FETCH, TB_OP_SW, 6'b0, 1'b1, 1'b0);
    applyStimulus(T_DECODE, TB_OP_SW, 6'b0, 1'b0, 1'b0);
    applyStimulus(T_MEMADR, TB_OP_SW, 6'b0, 1'b0, 1'b0);
    bus.Op      = TB_OP_SW;
    bus.mem_rdy = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput(resetExpect());
    @(posedge clk);
    #1;
    checkOutput(resetExpect());
    rst_n = 1'b1;
    runInstruction(TB_OP_J, 6'b000000, 1, 0, -1);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0) op = 6'($urandom);
      else                           op = legalOps[$urandom_range(0, 5)];
      if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
      else                           fn = legalFns[$urandom_range(0, 4)];
      runInstruction(op, fn, -1, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
